// File: rtl/change_event_logger_if.sv
// Event-record handshake between the change logger (master) and a consumer (slave).
//   ev_valid : record available at head of the log
//   ev_ready : consumer takes the head record this cycle
//   ev_data  : logged bus value
//   ev_time  : timestamp at which the value was sampled
//   ev_lost  : one or more events were dropped just before this record
interface change_event_logger_if #(
    parameter int DATA_W = 4,
    parameter int TS_W   = 16
);
    logic              ev_valid;
    logic              ev_ready;
    logic [DATA_W-1:0] ev_data;
    logic [TS_W-1:0]   ev_time;
    logic              ev_lost;

    modport master (output ev_valid, ev_data, ev_time, ev_lost, input ev_ready);
    modport slave  (input ev_valid, ev_data, ev_time, ev_lost, output ev_ready);
endinterface

// File: rtl/change_event_logger.sv
// Value-change logger: samples a narrow bus on enabled cycles, and on every
// change (plus the first sample after reset) stores {value, timestamp, lost}
// in a show-ahead FIFO drained over a valid/ready interface.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   sample_en     : sample_data is valid this cycle
//   sample_data   : monitored bus
//   ev            : event record output (master side of change_event_logger_if)
//   fifo_level    : number of stored records
//   drop_cnt      : saturating count of events dropped on a full FIFO
//   clear_drops   : synchronous clear of drop_cnt (wins over a same-cycle drop)
module change_event_logger #(
    parameter int DATA_W = 4,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sample_en,
    input  logic [DATA_W-1:0]        sample_data,
    change_event_logger_if.master    ev,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [DROP_W-1:0]        drop_cnt,
    input  logic                     clear_drops
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   time_s;
        logic              lost;
    } rec_t;

    rec_t              mem_q [DEPTH];
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [DATA_W-1:0] last_q, last_d;
    logic              first_q, first_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              lost_q, lost_d;

    logic trigger, pop, push, drop, full;
    rec_t rec_d, head;

    always_comb begin
        trigger = sample_en & (first_q | (sample_data != last_q));
        full    = (level_q == LVL_W'(DEPTH));
        pop     = (level_q != '0) & ev.ev_ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push    = trigger & (~full | pop);
        drop    = trigger & full & ~pop;

        rec_d.data   = sample_data;
        rec_d.time_s = ts_q;
        rec_d.lost   = lost_q;

        ts_d     = ts_q + TS_W'(1);
        last_d   = sample_en ? sample_data : last_q;
        first_d  = first_q & ~sample_en;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        drop_d = drop_q;
        if (clear_drops)
            drop_d = '0;
        else if (drop && (drop_q != '1))
            drop_d = drop_q + DROP_W'(1);

        // push and drop are mutually exclusive, so the order here is free.
        lost_d = lost_q;
        if (push)
            lost_d = 1'b0;
        else if (drop)
            lost_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            last_q   <= '0;
            first_q  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
            lost_q   <= 1'b0;
        end else begin
            ts_q     <= ts_d;
            last_q   <= last_d;
            first_q  <= first_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
            lost_q   <= lost_d;
        end
    end

    // Storage is not reset; the output gating below hides stale contents.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem_q[wr_ptr_q] <= rec_d;
    end

    always_comb begin
        head        = mem_q[rd_ptr_q];
        ev.ev_valid = (level_q != '0);
        ev.ev_data  = ev.ev_valid ? head.data   : '0;
        ev.ev_time  = ev.ev_valid ? head.time_s : '0;
        ev.ev_lost  = ev.ev_valid ? head.lost   : 1'b0;
        fifo_level  = level_q;
        drop_cnt    = drop_q;
    end
endmodule

// File: tb/tb_change_event_logger.sv
module tb_change_event_logger;
    localparam int DW = 4, TW = 4, DP = 8, DRW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sample_en = 1'b0;
    logic [DW-1:0] sample_data = '0;
    logic          clear_drops = 1'b0;
    logic [3:0]    fifo_level;
    logic [DRW-1:0] drop_cnt;

    change_event_logger_if #(.DATA_W(DW), .TS_W(TW)) ifc ();

    change_event_logger #(.DATA_W(DW), .TS_W(TW), .DEPTH(DP), .DROP_W(DRW)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .sample_data (sample_data),
        .ev          (ifc),
        .fifo_level  (fifo_level),
        .drop_cnt    (drop_cnt),
        .clear_drops (clear_drops)
    );

    always #5 clk = ~clk;

    // Reference model: an event log as a queue of records.
    typedef struct {
        logic [DW-1:0] d;
        int            t;
        bit            l;
    } rec_t;
    rec_t          q[$];
    int            m_ts;
    logic [DW-1:0] m_last;
    bit            m_first, m_lost;
    int            m_drops;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit   pop, trig;
        rec_t r;
        if (rst) begin
            q.delete();
            m_ts = 0; m_last = '0; m_first = 1; m_lost = 0; m_drops = 0;
        end else begin
            pop  = (q.size() != 0) && ifc.ev_ready;
            trig = sample_en && (m_first || sample_data != m_last);
            if (sample_en) begin m_last = sample_data; m_first = 0; end
            if (pop) void'(q.pop_front());
            if (trig) begin
                if (q.size() < DP) begin
                    r.d = sample_data; r.t = m_ts; r.l = m_lost;
                    q.push_back(r);
                    m_lost = 0;
                end else begin
                    m_lost = 1;
                    if (m_drops < 2**DRW - 1) m_drops++;
                end
            end
            if (clear_drops) m_drops = 0;
            m_ts = (m_ts + 1) % (2**TW);
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Continuous comparison of every output against the model.
    initial forever begin
        @(negedge clk);
        chk("m_valid", ifc.ev_valid, (q.size() != 0));
        chk("m_level", fifo_level, q.size());
        chk("m_drops", drop_cnt, m_drops);
        if (q.size() != 0) begin
            chk("m_data", ifc.ev_data, q[0].d);
            chk("m_time", ifc.ev_time, q[0].t);
            chk("m_lost", ifc.ev_lost, q[0].l);
        end else begin
            chk("m_data0", ifc.ev_data, 0);
            chk("m_time0", ifc.ev_time, 0);
            chk("m_lost0", ifc.ev_lost, 0);
        end
    end

    task automatic drive(input logic e, input logic [DW-1:0] d,
                         input logic r = 1'b0, input logic c = 1'b0);
        sample_en = e; sample_data = d; ifc.ev_ready = r; clear_drops = c;
        @(negedge clk);
    endtask

    logic [DW-1:0] prev;

    initial begin
        ifc.ev_ready = 1'b0;
        // Reset state
        rst = 1'b1;
        drive(0, 0); drive(0, 0);
        chk("rst_valid", ifc.ev_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_data", ifc.ev_data, 0);
        rst = 1'b0;

        // First sample at ts=3 is always logged, one cycle latency
        drive(0, 0); drive(0, 0); drive(0, 0);
        drive(1, 4'b0101);
        chk("first_valid", ifc.ev_valid, 1);
        chk("first_data", ifc.ev_data, 4'b0101);
        chk("first_time", ifc.ev_time, 3);
        chk("first_lost", ifc.ev_lost, 0);
        chk("first_level", fifo_level, 1);

        // Held value logs nothing; change at ts=15 logs one record
        repeat (10) drive(1, 4'b0101);
        drive(0, 4'b0101);
        drive(1, 4'b1010);
        chk("hold_level", fifo_level, 2);
        for (int i = 0; i < 4; i++) drive(0, 4'(i));
        chk("dis_level", fifo_level, 2);
        drive(0, 0, 1);
        chk("second_data", ifc.ev_data, 4'b1010);
        chk("second_time", ifc.ev_time, 15);
        drive(0, 0, 1);
        chk("drained", ifc.ev_valid, 0);

        // Overflow: 10 changes into depth 8
        for (int i = 0; i < 10; i++) drive(1, 4'(i));
        chk("ovf_level", fifo_level, 8);
        chk("ovf_drop", drop_cnt, 2);
        for (int i = 0; i < 8; i++) begin
            chk("drain_lost", ifc.ev_lost, 0);
            drive(0, 0, 1);
        end
        chk("ovf_empty", fifo_level, 0);
        drive(1, 4'd12);
        chk("lost_flag", ifc.ev_lost, 1);
        chk("lost_data", ifc.ev_data, 12);

        // Full + pop + change in one cycle: accepted
        for (int i = 0; i < 7; i++) drive(1, 4'(i));
        chk("refill_level", fifo_level, 8);
        drive(1, 4'd13, 1);
        chk("pp_level", fifo_level, 8);
        chk("pp_drop", drop_cnt, 2);

        // Clear wins over a same-cycle drop
        drive(1, 4'd14, 0, 1);
        chk("clr_drop", drop_cnt, 0);

        // Saturation
        for (int i = 0; i < 260; i++) drive(1, (i % 2) ? 4'd3 : 4'd4);
        chk("sat_drop", drop_cnt, 255);
        prev = sample_data;

        // Reset mid-stream with 5 queued and ev_ready toggling
        drive(0, prev, 1); drive(0, prev, 1); drive(0, prev, 1);
        chk("pre_rst_level", fifo_level, 5);
        rst = 1'b1;
        drive(0, prev, 1);
        drive(0, prev, 0);
        chk("mrst_valid", ifc.ev_valid, 0);
        chk("mrst_level", fifo_level, 0);
        chk("mrst_drop", drop_cnt, 0);
        rst = 1'b0;
        drive(1, prev);
        chk("post_rst_level", fifo_level, 1);
        chk("post_rst_data", ifc.ev_data, prev);
        chk("post_rst_lost", ifc.ev_lost, 0);

        // Timestamp wrap: records at ts 15 then 1, no event for the wrap itself
        drive(0, prev, 1);
        for (int k = 0; k < 20 && m_ts != 15; k++) drive(0, prev);
        chk("wait_ts15", m_ts, 15);
        drive(1, 4'd7);
        drive(0, 4'd7);
        drive(1, 4'd8);
        chk("wrap_level", fifo_level, 2);
        chk("wrap_t0", ifc.ev_time, 15);
        drive(0, 4'd8, 1);
        chk("wrap_t1", ifc.ev_time, 1);
        chk("wrap_d1", ifc.ev_data, 8);
        drive(0, 4'd8, 1);
        drive(0, 4'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
